// File: rtl/fpu_add_pkg.sv
// rtl/fpu_add_pkg.sv - shared types and helpers for the byte-serial FPU adder
//
// Contents:
//   state_t      controller states {IDLE, RUN, DONE}
//   SLICE_W      width of the shared adder slice in bits
//   slice_count  number of slice passes needed for a given operand width
package fpu_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 8;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla8bit.sv
// rtl/cla8bit.sv - 8-bit carry-lookahead adder slice
//
// Ports:
//   A, B  in   8-bit addends
//   Ci    in   carry in
//   S     out  8-bit sum
//   Co    out  carry out of bit 7
module CLA8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Ci,
    output logic [7:0] S,
    output logic       Co
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Each carry is the flat lookahead sum-of-products
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]Ci, not a ripple chain.
    always_comb begin
        logic acc;
        logic pp;
        c = '0;
        c[0] = Ci;
        for (int i = 0; i < 8; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & Ci);
        end
    end

    assign S  = p ^ c[7:0];
    assign Co = c[8];

endmodule

// File: rtl/fpu_add_sequencer.sv
// rtl/fpu_add_sequencer.sv - byte-serial WIDTH-bit add/subtract over one shared CLA8 slice
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready high only in IDLE
//   a, b, sub, cin      operands; sub=1 gives a-b (cin ignored), sub=0 gives a+b+cin
//   out_valid/out_ready result handshake; out_valid high only in DONE
//   sum, cout, ovf      registered result, carry out of MSB, signed overflow
//   busy                controller is not in IDLE
module fpu_add_sequencer
    import fpu_add_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
            $error("fpu_add_sequencer: WIDTH must be a nonzero multiple of 8");
        end
    endgenerate

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               last_slice;

    assign slice_a    = a_q[SLICE_W*int'(k) +: SLICE_W];
    assign slice_b    = b_q[SLICE_W*int'(k) +: SLICE_W];
    assign last_slice = (k == KW'(NSLICE - 1));

    CLA8bit u_slice (
        .A  (slice_a),
        .B  (slice_b),
        .Ci (carry_q),
        .S  (slice_s),
        .Co (slice_co)
    );

    // Handshake outputs decode the state register only, so neither in_valid
    // nor out_ready reaches an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b once here and
                        // seed the carry so the slice only ever adds.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum[SLICE_W*int'(k) +: SLICE_W] <= slice_s;
                    carry_q <= slice_co;
                    if (last_slice) begin
                        cout  <= slice_co;
                        ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb/tb_fpu_add_sequencer.sv - self-checking bench for fpu_add_sequencer
module tb_fpu_add_sequencer;

    localparam int W = 32;
    localparam int LAT = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_vec;
    int n_fail;

    fpu_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed and unsigned integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic msub, input logic mcin,
                         output logic [W-1:0] rs, output logic rc, output logic ro);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'({32'd0, ma});
        ub = longint'({32'd0, mb});
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (msub) begin
            ur = ua - ub;
            sr = sa - sb;
            rc = (ua >= ub);
        end else begin
            ur = ua + ub + longint'(mcin);
            sr = sa + sb + longint'(mcin);
            rc = (ur >= 64'sd4294967296);
        end
        rs = ur[W-1:0];
        ro = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // Presents one operation and returns at the falling edge after acceptance.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic icin);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stayed 0");
        end
        a = ia; b = ib; sub = isub; cin = icin; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
    endtask

    // Called at the falling edge after acceptance; counts edges to out_valid.
    task automatic wait_result(input string name, input logic check_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) check({name, "_latency"}, n, LAT);
        else if (n >= 20) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_result(input string name, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, ec);
        check({name, "_ovf"}, ovf, eo);
    endtask

    task automatic release_result(input int delay);
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    vec_t vt[$];
    logic [W-1:0] ms;
    logic mc, mo;
    logic [W-1:0] ra, rb;
    logic rsub, rcin;
    logic seen;

    initial begin
        n_vec = 0;
        n_fail = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;

        vt.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
        vt.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vt.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
        vt.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0});
        vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        vt.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1});
        vt.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0});

        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_sum", sum, 0);
        check("reset_cout_ovf", {cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            issue(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin);
            check($sformatf("vec%0d_busy", i), {busy, in_ready}, 2'b10);
            wait_result($sformatf("vec%0d", i), 1'b1);
            check_result($sformatf("vec%0d", i), vt[i].e_sum, vt[i].e_cout, vt[i].e_ovf);
            release_result(0);
            check($sformatf("vec%0d_idle", i), {in_ready, out_valid, busy}, 3'b100);
        end

        // Backpressure: result held while new operands wait at the input.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_result("bp", 1'b1);
        in_valid = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b0; cin = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid_ready", c), {out_valid, in_ready}, 2'b10);
            check_result($sformatf("bp_hold%0d", c), 32'h0000_0100, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_back_idle", {in_ready, out_valid}, 2'b10);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", {busy, in_ready}, 2'b10);
        wait_result("bp2", 1'b1);
        check_result("bp2", 32'h0000_0031, 1'b0, 1'b0);
        release_result(0);

        // Reset during RUN, after two slice edges.
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready_busy", {in_ready, busy, out_valid}, 3'b100);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_cout_ovf", {cout, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_mid_no_out_valid", seen, 0);
        check("rst_mid_in_ready", in_ready, 1);

        // Randomised operations against the integer reference.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) ra = 32'hFFFF_FFFF;
            if (i % 8 == 1) rb = 32'h8000_0000;
            rsub = $urandom; rcin = $urandom;
            model(ra, rb, rsub, rcin, ms, mc, mo);
            issue(ra, rb, rsub, rcin);
            wait_result($sformatf("rnd%0d", i), 1'b1);
            check_result($sformatf("rnd%0d", i), ms, mc, mo);
            release_result($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_add_sequencer.md
# fpu_add_sequencer

Multi-cycle wide-operand adder/subtractor controller that reuses a single 8-bit carry-lookahead adder slice over several cycles. It performs WIDTH-bit add/subtract one byte per cycle, least-significant byte first, with a registered inter-slice carry. It sits in the FPU mantissa/exponent path, where area matters more than single-cycle latency. It uses a valid/ready handshake on both the input and output sides.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 8 and ≥ 8. NSLICE = WIDTH/8.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A−B, 0 = A+B.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result held on sum/cout/ovf.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB (sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: latch a_q=a, b_q = sub ? ~b : b, carry_q = sub ? 1 : cin, clear slice counter k=0, and go to RUN.
- RUN: each cycle, the CLA slice adds a_q[8k+7:8k] + b_q[8k+7:8k] + carry_q.
  - Write the result to sum[8k+7:8k] and set carry_q ← slice Co, k ← k+1.
  - On k = NSLICE−1: also set cout ← Co and ovf ← (a_q[MSB] == b_q[MSB]) && (sum MSB result ≠ a_q[MSB]), then go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and operands change after acceptance have no effect.
- sum, cout and ovf are registered. They are stable throughout DONE and retain their last values in IDLE and during the next RUN (except sum slices as they are overwritten).
- Reset values: state=IDLE, k=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1, carry_q=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No out_valid is produced for the aborted operation.

## Timing
- Acceptance edge E0. Slices are computed on edges E1..E_NSLICE, and out_valid rises after E_NSLICE. Latency is NSLICE cycles (4 for WIDTH=32).
- The out_valid&&out_ready edge returns the block to IDLE; in_ready is 1 in the following cycle. No same-cycle accept from DONE.
- Minimum issue interval: NSLICE+2 cycles.
- in_ready and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- The carry chain within a cycle is limited to one 8-bit CLA slice plus the carry_q mux.

## Structure
- Shared package fpu_add_pkg:
  - typedef enum for states {IDLE, RUN, DONE}
  - localparam SLICE_W = 8
  - function for slice count (WIDTH/SLICE_W).
- Exactly one instance of the existing CLA8bit as the datapath slice:
  - A, B driven by muxed byte k of a_q/b_q
  - Ci from carry_q
  - S and Co captured into registers.
- Counter width: $clog2(NSLICE), minimum 1. Elaboration check: WIDTH % 8 == 0.

## Test plan
- Simple add: a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0 → sum=0x0000_0100, cout=0, ovf=0; out_valid exactly 4 edges after acceptance.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0001 → sum=0x0000_0000, cout=1, ovf=0; carry propagates through all four slices.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001 → sum=0x8000_0000, ovf=1, cout=0.
- Subtract with borrow:
  - a=5, b=7, sub=1, cin=1 → sum=0xFFFF_FFFE, cout=0, ovf=0 (cin ignored).
  - a=7, b=5, sub=1 → sum=0x0000_0002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → out_valid, sum, cout and ovf stay stable; in_ready=0; the new operands are not accepted. Raise out_ready → IDLE next edge, in_ready=1, then the new operation is accepted.
- Reset mid-RUN: assert rst_n=0 after 2 slice edges → all outputs immediately at reset values; in_ready=1 after release; no out_valid ever appears for the aborted operation.
